zvc_stream_compressor: RTL
==========================

// Module: zvc_stream_compressor
// PURPOSE
//  Parametrised zero-value compressor for lowered-IFM (LIFM) lines with mapping tables (MT).
//  Per lane, a bubble is a lane whose selected mask source is zero.
//  Bubbles are removed and survivors are packed toward lane 0; tail lanes are zero-filled.
//  Sits between the lowering unit and the PE line buffer.
//  Generalises the fixed 128-lane compressor:
//   - any power-of-two lane count
//   - valid/ready flow control with stall
//   - selectable mask mode, bypass
//   - survivor count output
//   - bubble statistics counter
// PARAMETERS
//  LANES          128  lanes per line; power of 2, 8..256
//  WORD_WIDTH       8  LIFM word width
//  DIST_WIDTH       7  MT distance field width
//  MAX_LIFM_RSIZ    4  MT fields per lane
//  PSUM_WIDTH     $clog2(LANES)+1  prefix-sum / count width
//  STAT_WIDTH      32  bubble statistics counter width
// PORTS
//  clk         in   1                               clock, rising edge
//  reset       in   1                               async, active-high
//  in_valid    in   1                               input line valid
//  in_ready    out  1                               block accepts line
//  in_mode     in   2                               0: MT==0; 1: LIFM==0; 2: both==0; 3: bypass
//  lifm_line   in   LANES*WORD_WIDTH                lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//  mt_line     in   LANES*DIST_WIDTH*MAX_LIFM_RSIZ  lane i MT entry
//  out_valid   out  1                               compressed line valid
//  out_ready   in   1                               downstream accepts
//  lifm_comp   out  LANES*WORD_WIDTH                packed LIFM, tail zero
//  mt_comp     out  LANES*DIST_WIDTH*MAX_LIFM_RSIZ  packed MT, tail zero
//  out_count   out  PSUM_WIDTH                      survivors in line, 0..LANES
//  stat_clear  in   1                               sync clear of stat_bubbles
//  stat_bubbles out STAT_WIDTH                      saturating total bubbles removed
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-line):
//     all pipe regs, valids, outputs, count and stat_bubbles -> 0; in-flight lines dropped.
//  - Mask: mask[i] = 1 if lane i is a bubble per in_mode, evaluated at acceptance; mode 3 gives mask = 0.
//  - Stage 1 (S1):
//     on in_valid & in_ready, register the line, the exclusive prefix sum psum[i] = sum mask[0..i-1],
//     and the bubble total.
//  - Stage 2 (S2):
//     shifter moves lane i to lane i - psum[i] when mask[i] = 0;
//     registers the result and out_count = LANES - total.
//  - Latency: 2 cycles from acceptance to out_valid with no stall; throughput 1 line/clk.
//  - Handshake:
//     - advance_s2 = !out_valid | out_ready
//     - advance_s1 = !s1_valid | advance_s2
//     - in_ready = advance_s1, combinational from out_ready
//     - Outputs hold stable while out_valid & !out_ready; no line is lost or duplicated.
//     - in_valid may drop without in_ready.
//  - Edge cases:
//     - All lanes bubble -> out_count = 0, data all zero, out_valid still asserted.
//     - No bubbles -> output equals input, out_count = LANES.
//  - Statistics:
//     - stat_bubbles += total on each S2 load; saturates at all-ones.
//     - stat_clear has priority: cleared that cycle, that cycle's increment discarded.
//  - Widths: psum and count are PSUM_WIDTH unsigned; the LANES count needs the extra bit.
// STRUCTURE
//  Shared package zvc_pkg:
//   - mode encodings ZVC_MODE_MT / LIFM / BOTH / BYPASS
//   - lane-slice macros
//   - psum width function
//  Sub-module zvc_prefix_sum #(LANES, PSUM_WIDTH):
//   - combinational, log-depth (Ladner-Fischer)
//   - outputs exclusive psum and total
//  Shifter: log2(LANES) collapse stages inline, stage k shifts by bit k of psum.
// TESTING
//  1. LANES=8, mode 0, MT zero at lanes 1,4,6, LIFM = lane index
//     -> lifm_comp {0,2,3,5,7,0,0,0}, out_count 5, 2-cycle latency.
//  2. Mode 3, random line -> output equals input, out_count 8, stat_bubbles unchanged.
//  3. All-zero line, mode 2 -> out_count 0, all-zero data, stat_bubbles += 8.
//  4. Stream 20 lines, out_ready toggled randomly
//     -> scoreboard in order, no loss or duplication, outputs stable while stalled.
//  5. Assert reset mid-stream with S1 and S2 full -> outputs 0 same cycle, first post-reset line correct.
//  6. STAT_WIDTH=4, feed 3 lines of 8 bubbles -> saturates at 15.
//     stat_clear coincident with a load -> 0.

Source files
------------

// File: rtl/zvc_pkg.sv
// Shared types and helpers for the zero-value stream compressor.
// Mode encodings, lane-slice macro and prefix-sum width helper.
`ifndef ZVC_PKG_SV
`define ZVC_PKG_SV
`define ZVC_LANE(vec, idx, width) vec[(idx)*(width) +: (width)]

package zvc_pkg;

    typedef enum logic [1:0] {
        ZVC_MODE_MT     = 2'd0,
        ZVC_MODE_LIFM   = 2'd1,
        ZVC_MODE_BOTH   = 2'd2,
        ZVC_MODE_BYPASS = 2'd3
    } zvc_mode_e;

    // One extra bit so a full line (LANES survivors) is representable.
    function automatic int unsigned zvc_psum_width(input int unsigned lanes);
        return $clog2(lanes) + 1;
    endfunction

endpackage

`endif

// File: rtl/zvc_stream_compressor_if.sv
// Line-level valid/ready bus between lowering unit, compressor and PE line buffer.
// master drives lines in and accepts results; slave is the compressor.
interface zvc_stream_compressor_if
    import zvc_pkg::*;
#(
    parameter int unsigned LANES         = 128,
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned DIST_WIDTH    = 7,
    parameter int unsigned MAX_LIFM_RSIZ = 4,
    parameter int unsigned PSUM_WIDTH    = zvc_psum_width(LANES)
);
    localparam int unsigned MT_WIDTH = DIST_WIDTH * MAX_LIFM_RSIZ;

    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  in_mode;
    logic [LANES*WORD_WIDTH-1:0] lifm_line;
    logic [LANES*MT_WIDTH-1:0]   mt_line;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*WORD_WIDTH-1:0] lifm_comp;
    logic [LANES*MT_WIDTH-1:0]   mt_comp;
    logic [PSUM_WIDTH-1:0]       out_count;

    modport master (
        output in_valid, in_mode, lifm_line, mt_line, out_ready,
        input  in_ready, out_valid, lifm_comp, mt_comp, out_count
    );

    modport slave (
        input  in_valid, in_mode, lifm_line, mt_line, out_ready,
        output in_ready, out_valid, lifm_comp, mt_comp, out_count
    );

endinterface

// File: rtl/zvc_prefix_sum.sv
// Log-depth (Ladner-Fischer) exclusive prefix sum of the bubble mask.
// Purely combinational; total is the inclusive sum over all lanes.
module zvc_prefix_sum #(
    parameter int unsigned LANES      = 128,
    parameter int unsigned PSUM_WIDTH = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0]                 mask,
    output logic [LANES-1:0][PSUM_WIDTH-1:0] psum,
    output logic [PSUM_WIDTH-1:0]            total
);
    localparam int unsigned LOG_LANES = $clog2(LANES);

    logic [LANES-1:0][PSUM_WIDTH-1:0] lvl [LOG_LANES+1];

    // Level k+1: lanes with bit k set add the last lane of the lower half-block.
    always_comb begin
        lvl   = '{default: '0};
        psum  = '0;
        total = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lvl[0][i] = PSUM_WIDTH'(mask[i]);
        end
        for (int unsigned k = 0; k < LOG_LANES; k++) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (((i >> k) & 1) != 0) begin
                    lvl[k+1][i] = lvl[k][i] + lvl[k][((i >> (k + 1)) << (k + 1)) + (1 << k) - 1];
                end else begin
                    lvl[k+1][i] = lvl[k][i];
                end
            end
        end
        for (int unsigned i = 1; i < LANES; i++) begin
            psum[i] = lvl[LOG_LANES][i-1];
        end
        total = lvl[LOG_LANES][LANES-1];
    end

endmodule

// File: rtl/zvc_stream_compressor.sv
// Zero-value compressor: drops bubble lanes of an LIFM/MT line and packs survivors to lane 0.
// Two register stages (mask+prefix sum, then collapse shifter) with valid/ready stall.
module zvc_stream_compressor
    import zvc_pkg::*;
#(
    parameter int unsigned LANES         = 128,
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned DIST_WIDTH    = 7,
    parameter int unsigned MAX_LIFM_RSIZ = 4,
    parameter int unsigned PSUM_WIDTH    = zvc_psum_width(LANES),
    parameter int unsigned STAT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    zvc_stream_compressor_if.slave  bus,
    input  logic                    stat_clear,
    output logic [STAT_WIDTH-1:0]   stat_bubbles
);
    localparam int unsigned MT_WIDTH   = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int unsigned LANE_WIDTH = WORD_WIDTH + MT_WIDTH;
    localparam int unsigned LOG_LANES  = $clog2(LANES);
    localparam int unsigned ACC_WIDTH  = ((STAT_WIDTH > PSUM_WIDTH) ? STAT_WIDTH : PSUM_WIDTH) + 1;

    logic [LANES-1:0]                 mask_c;
    logic [LANES-1:0][PSUM_WIDTH-1:0] psum_c;
    logic [PSUM_WIDTH-1:0]            total_c;
    logic                             advance_s1;
    logic                             advance_s2;
    logic                             s1_load;
    logic                             s2_load;

    logic                             s1_valid;
    logic [LANES*WORD_WIDTH-1:0]      s1_lifm;
    logic [LANES*MT_WIDTH-1:0]        s1_mt;
    logic [LANES-1:0]                 s1_mask;
    logic [LANES-1:0][PSUM_WIDTH-1:0] s1_psum;
    logic [PSUM_WIDTH-1:0]            s1_total;

    logic [LANES-1:0][LANE_WIDTH-1:0] sh_data [LOG_LANES+1];
    logic [LANES-1:0][PSUM_WIDTH-1:0] sh_psum [LOG_LANES+1];
    logic [LANES-1:0]                 sh_keep [LOG_LANES+1];
    logic [LANES*WORD_WIDTH-1:0]      lifm_comp_c;
    logic [LANES*MT_WIDTH-1:0]        mt_comp_c;
    logic [LANES-1:0]                 unused_psum_msb;
    logic [ACC_WIDTH-1:0]             stat_sum_c;

    // Bubble mask for the line currently offered on the input.
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            case (zvc_mode_e'(bus.in_mode))
                ZVC_MODE_MT:     mask_c[i] = ~|`ZVC_LANE(bus.mt_line, i, MT_WIDTH);
                ZVC_MODE_LIFM:   mask_c[i] = ~|`ZVC_LANE(bus.lifm_line, i, WORD_WIDTH);
                ZVC_MODE_BOTH:   mask_c[i] = ~|`ZVC_LANE(bus.mt_line, i, MT_WIDTH)
                                           & ~|`ZVC_LANE(bus.lifm_line, i, WORD_WIDTH);
                ZVC_MODE_BYPASS: mask_c[i] = 1'b0;
            endcase
        end
    end

    zvc_prefix_sum #(
        .LANES      (LANES),
        .PSUM_WIDTH (PSUM_WIDTH)
    ) u_prefix_sum (
        .mask  (mask_c),
        .psum  (psum_c),
        .total (total_c)
    );

    assign advance_s2   = !bus.out_valid || bus.out_ready;
    assign advance_s1   = !s1_valid || advance_s2;
    assign bus.in_ready = advance_s1;
    assign s1_load      = bus.in_valid && advance_s1;
    assign s2_load      = s1_valid && advance_s2;

    // Stage 1: capture the line together with its prefix sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_lifm  <= '0;
            s1_mt    <= '0;
            s1_mask  <= '0;
            s1_psum  <= '0;
            s1_total <= '0;
        end else begin
            if (advance_s1) begin
                s1_valid <= bus.in_valid;
            end
            if (s1_load) begin
                s1_lifm  <= bus.lifm_line;
                s1_mt    <= bus.mt_line;
                s1_mask  <= mask_c;
                s1_psum  <= psum_c;
                s1_total <= total_c;
            end
        end
    end

    // Collapse network: stage k moves a survivor down by 2^k when psum bit k is set.
    // Applying the bits LSB first keeps survivors in order and never collides.
    always_comb begin
        sh_data         = '{default: '0};
        sh_psum         = '{default: '0};
        sh_keep         = '{default: '0};
        lifm_comp_c     = '0;
        mt_comp_c       = '0;
        unused_psum_msb = '0;
        for (int unsigned p = 0; p < LANES; p++) begin
            sh_keep[0][p]      = !s1_mask[p];
            sh_psum[0][p]      = s1_psum[p];
            sh_data[0][p]      = s1_mask[p] ? '0
                                            : {`ZVC_LANE(s1_mt, p, MT_WIDTH), `ZVC_LANE(s1_lifm, p, WORD_WIDTH)};
            unused_psum_msb[p] = s1_psum[p][PSUM_WIDTH-1];
        end
        for (int unsigned k = 0; k < LOG_LANES; k++) begin
            for (int unsigned p = 0; p < LANES; p++) begin
                if (sh_keep[k][p] && !sh_psum[k][p][k]) begin
                    sh_keep[k+1][p] = 1'b1;
                    sh_psum[k+1][p] = sh_psum[k][p];
                    sh_data[k+1][p] = sh_data[k][p];
                end
                if ((p + (1 << k) < LANES) && sh_keep[k][(p + (1 << k)) & (LANES - 1)]
                        && sh_psum[k][(p + (1 << k)) & (LANES - 1)][k]) begin
                    sh_keep[k+1][p] = 1'b1;
                    sh_psum[k+1][p] = sh_psum[k][(p + (1 << k)) & (LANES - 1)];
                    sh_data[k+1][p] = sh_data[k][(p + (1 << k)) & (LANES - 1)];
                end
            end
        end
        for (int unsigned p = 0; p < LANES; p++) begin
            `ZVC_LANE(lifm_comp_c, p, WORD_WIDTH) = sh_data[LOG_LANES][p][WORD_WIDTH-1:0];
            `ZVC_LANE(mt_comp_c, p, MT_WIDTH)     = sh_data[LOG_LANES][p][LANE_WIDTH-1:WORD_WIDTH];
        end
    end

    // Stage 2: register the packed line and its survivor count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.lifm_comp <= '0;
            bus.mt_comp   <= '0;
            bus.out_count <= '0;
        end else if (advance_s2) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.lifm_comp <= lifm_comp_c;
                bus.mt_comp   <= mt_comp_c;
                bus.out_count <= PSUM_WIDTH'(LANES) - s1_total;
            end
        end
    end

    assign stat_sum_c = ACC_WIDTH'(stat_bubbles) + ACC_WIDTH'(s1_total);

    // Saturating bubble counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_bubbles <= '0;
        end else if (stat_clear) begin
            stat_bubbles <= '0;
        end else if (s2_load) begin
            stat_bubbles <= (stat_sum_c[ACC_WIDTH-1:STAT_WIDTH] != '0) ? '1
                                                                       : stat_sum_c[STAT_WIDTH-1:0];
        end
    end

endmodule
